// File: rtl/dff_resp_checker.sv
// dff_resp_checker: cycle-exact response monitor for an enabled D flip-flop
// Observes the stimulus (mon_rst/mon_en/mon_d) and the response (mon_q/mon_qb)
// of a flop, runs a reference model and reports the outcome of each run.
// Ports:
//   clk       - checker clock, all state updates on the rising edge
//   reset     - asynchronous active-low checker reset
//   start     - one-cycle pulse arms a run (ignored while busy)
//   mon_rst   - observed flop reset (active high)
//   mon_en    - observed flop enable
//   mon_d     - observed flop data input
//   mon_q     - observed flop q
//   mon_qb    - observed flop qb
//   busy      - run in progress (waiting for flop reset, or comparing)
//   done      - run finished, held until the next start
//   pass      - with done: run finished with zero errors
//   err_cnt   - number of mismatching cycles, saturating
//   fail_cyc  - cycle index of the first mismatch, 0 if none
//   fail_code - first mismatch cause: bit0 q wrong, bit1 qb not ~q
module dff_resp_checker #(
  parameter int NUM_CHECKS   = 32,
  parameter int CNT_W        = 8,
  parameter int ERR_W        = 8,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mon_rst,
  input  logic             mon_en,
  input  logic             mon_d,
  input  logic             mon_q,
  input  logic             mon_qb,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CNT_W-1:0] fail_cyc,
  output logic [1:0]       fail_code
);
  typedef enum logic [1:0] {IDLE, WAIT_RST, CHECK, DONE} state_t;
  state_t state, state_nx;
  logic exp_q, exp_now, mis_q, mis_qb, mismatch, last, arm;
  logic [CNT_W-1:0] cyc_cnt, cyc_inc;
  // The flop resets asynchronously, so q must already read 0 while mon_rst is high.
  assign exp_now = mon_rst ? 1'b0 : exp_q;
  // Case inequality so that unknown q/qb values count as mismatches in simulation.
  assign mis_q = mon_q !== exp_now;
  assign mis_qb = mon_qb !== ~mon_q;
  assign mismatch = mis_q | mis_qb;
  assign cyc_inc = cyc_cnt + 1'b1;
  assign last = cyc_inc == CNT_W'(NUM_CHECKS);
  assign arm = start && (state == IDLE || state == DONE);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = WAIT_RST;
      WAIT_RST:   if (mon_rst) state_nx = CHECK;
      CHECK:      if (last || (STOP_ON_FAIL && mismatch)) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = state == WAIT_RST || state == CHECK;
    done = state == DONE;
    pass = state == DONE && err_cnt == '0;
  end
  // A saturated error counter never returns to zero, so err_cnt == 0 marks the first mismatch.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      exp_q <= 1'b0;
      cyc_cnt <= '0;
      err_cnt <= '0;
      fail_cyc <= '0;
      fail_code <= '0;
    end else if (arm) begin
      cyc_cnt <= '0;
      err_cnt <= '0;
      fail_cyc <= '0;
      fail_code <= '0;
    end else begin
      if (busy) exp_q <= mon_rst ? 1'b0 : mon_en ? mon_d : exp_q;
      if (state == CHECK) begin
        cyc_cnt <= cyc_inc;
        if (mismatch) begin
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          if (err_cnt == '0) begin
            fail_cyc <= cyc_cnt;
            fail_code <= {mis_qb, mis_q};
          end
        end
      end
    end
endmodule

// File: tb/tb_dff_resp_checker.sv
// tb_dff_resp_checker: self-checking bench for dff_resp_checker
module tb_dff_resp_checker;
  localparam int NS [4] = '{32, 8, 1, 32};
  localparam int EW [4] = '{8, 8, 8, 2};
  localparam bit SS [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  typedef struct { logic rst, en, d, q, qb, st; } vec_t;
  typedef struct { string name; int kind; int err; int fc; int code; bit pass; } scen_t;
  logic clk, reset, start, mon_rst, mon_en, mon_d, mon_q, mon_qb;
  logic [3:0] busy_o, done_o, pass_o;
  logic [3:0][7:0] err_o, fcyc_o;
  logic [3:0][1:0] code_o;
  vec_t v[$];
  scen_t tbl [6];
  int n_cmp = 0, n_bad = 0;
  for (genvar g = 0; g < 4; g++) begin : u
    logic [EW[g]-1:0] e;
    dff_resp_checker #(.NUM_CHECKS(NS[g]), .CNT_W(8), .ERR_W(EW[g]), .STOP_ON_FAIL(SS[g])) dut (
      .clk(clk), .reset(reset), .start(start), .mon_rst(mon_rst), .mon_en(mon_en),
      .mon_d(mon_d), .mon_q(mon_q), .mon_qb(mon_qb), .busy(busy_o[g]), .done(done_o[g]),
      .pass(pass_o[g]), .err_cnt(e), .fail_cyc(fcyc_o[g]), .fail_code(code_o[g]));
    assign err_o[g] = 8'(e);
  end
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic chk_zero(input string nm);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s busy%0d", nm, d), int'(busy_o[d]), 0);
      chk($sformatf("%s done%0d", nm, d), int'(done_o[d]), 0);
      chk($sformatf("%s pass%0d", nm, d), int'(pass_o[d]), 0);
      chk($sformatf("%s err%0d", nm, d), int'(err_o[d]), 0);
      chk($sformatf("%s fcyc%0d", nm, d), int'(fcyc_o[d]), 0);
      chk($sformatf("%s code%0d", nm, d), int'(code_o[d]), 0);
    end
  endtask
  task automatic drive(input vec_t x);
    {mon_rst, mon_en, mon_d, mon_q, mon_qb} = {x.rst, x.en, x.d, x.q, x.qb};
  endtask
  // Flop behaviour plus fault injection; kinds: 0 good, 1 q stuck-at-1 from cycle 5,
  // 2 qb==q at cycle 3, 3 enable-hold good, 4 enable ignored in hold window,
  // 5 q flipped at cycle 2, 6 random resets and faults.
  task automatic build(input int kind, input int pre);
    logic qreg;
    vec_t x;
    qreg = 1'b0;
    v.delete();
    for (int i = 0; i < pre; i++) begin
      x = '{1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0};
      v.push_back(x);
    end
    for (int j = 0; j <= 32; j++) begin
      int k;
      k = j - 1;
      x.st = 1'b0;
      x.rst = kind == 6 ? (j == 0 || $urandom_range(7) == 0) : j <= 1;
      x.en = 1'($urandom);
      x.d = 1'($urandom);
      if (kind == 1 && k >= 1) x.en = 1'b0;
      if ((kind == 3 || kind == 4) && k >= 1) begin
        x.en = k == 1;
        x.d = k == 1 ? 1'b1 : k <= 11 ? 1'((k - 2) % 2) : x.d;
      end
      x.q = x.rst ? 1'b0 : qreg;
      x.qb = ~x.q;
      if (kind == 1 && k >= 5) begin x.q = 1'b1; x.qb = 1'b0; end
      if (kind == 2 && k == 3) x.qb = x.q;
      if (kind == 5 && k == 2) begin x.q = ~x.q; x.qb = ~x.q; end
      if (kind == 6 && $urandom_range(15) == 0) x.q = ~x.q;
      if (kind == 6 && $urandom_range(15) == 0) x.qb = x.q;
      qreg = x.rst ? 1'b0 : (kind == 4 && k >= 2 && k <= 11) ? x.d : x.en ? x.d : qreg;
      v.push_back(x);
    end
  endtask
  // Run-level reference: walks the vector list once, returns the vector index
  // whose edge ends the run and the expected result registers.
  function automatic void model(input int n, input bit stop, input int emax,
                                output int di, output int err, output int fc, output int code);
    bit waiting, seen;
    logic e;
    int cnt;
    waiting = 1'b1; seen = 1'b0; e = 1'b0; cnt = 0;
    di = 1000000; err = 0; fc = 0; code = 0;
    foreach (v[i]) begin
      if (di < i) break;
      if (waiting) waiting = !v[i].rst;
      else begin
        bit mq, mqb;
        mq = v[i].q !== (v[i].rst ? 1'b0 : e);
        mqb = v[i].qb !== ~v[i].q;
        if (mq || mqb) begin
          if (!seen) begin fc = cnt; code = 2 * int'(mqb) + int'(mq); seen = 1'b1; end
          if (err < emax) err++;
        end
        cnt++;
        if (cnt == n || (stop && (mq || mqb))) di = i;
      end
      e = v[i].rst ? 1'b0 : v[i].en ? v[i].d : e;
    end
  endfunction
  task automatic run_vecs(input bit [3:0] mask, input int t);
    int di [4], er [4], fc [4], cd [4];
    bit dn;
    for (int d = 0; d < 4; d++) model(NS[d], SS[d], (1 << EW[d]) - 1, di[d], er[d], fc[d], cd[d]);
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i <= v.size(); i++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++)
        if (mask[d]) begin
          chk($sformatf("done%0d@%0d", d, i - 1), int'(done_o[d]), int'(i - 1 >= di[d]));
          chk($sformatf("busy%0d@%0d", d, i - 1), int'(busy_o[d]), int'(i - 1 < di[d]));
        end
      if (i < v.size()) begin
        drive(v[i]);
        start = v[i].st;
      end
    end
    start = 1'b0;
    for (int d = 0; d < 4; d++)
      if (mask[d]) begin
        dn = di[d] < v.size();
        chk($sformatf("end done%0d", d), int'(done_o[d]), int'(dn));
        chk($sformatf("end pass%0d", d), int'(pass_o[d]), int'(dn && er[d] == 0));
        chk($sformatf("end err%0d", d), int'(err_o[d]), er[d]);
        chk($sformatf("end fcyc%0d", d), int'(fcyc_o[d]), fc[d]);
        chk($sformatf("end code%0d", d), int'(code_o[d]), cd[d]);
      end
    if (t >= 0) begin
      chk({tbl[t].name, " done"}, int'(done_o[0]), 1);
      chk({tbl[t].name, " pass"}, int'(pass_o[0]), int'(tbl[t].pass));
      chk({tbl[t].name, " err"}, int'(err_o[0]), tbl[t].err);
      chk({tbl[t].name, " fcyc"}, int'(fcyc_o[0]), tbl[t].fc);
      chk({tbl[t].name, " code"}, int'(code_o[0]), tbl[t].code);
    end
  endtask
  initial begin
    int c;
    tbl[0] = '{"good", 0, 0, 0, 0, 1'b1};
    tbl[1] = '{"q_stuck1", 1, 27, 5, 1, 1'b0};
    tbl[2] = '{"qb_err", 2, 1, 3, 2, 1'b0};
    tbl[3] = '{"hold_ok", 3, 0, 0, 0, 1'b1};
    tbl[4] = '{"hold_follow", 4, 5, 3, 1, 1'b0};
    tbl[5] = '{"flip_c2", 5, 1, 2, 1, 1'b0};
    clk = 1'b0; reset = 1'b0; start = 1'b1;
    {mon_rst, mon_en, mon_d, mon_q, mon_qb} = 5'b00001;
    repeat (2) @(negedge clk);
    chk_zero("rst_with_start");
    start = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk_zero("idle");
    for (int t = 0; t < 6; t++) begin
      build(tbl[t].kind, t % 3);
      run_vecs(4'hF, t);
    end
    repeat (8) begin
      build(6, $urandom_range(3));
      run_vecs(4'hF, -1);
    end
    build(0, 1);
    v[12].st = 1'b1;
    run_vecs(4'b1001, -1);
    build(2, 1);
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start = 1'b0;
      drive(v[i]);
    end
    @(negedge clk);
    chk("pre_reset err0", int'(err_o[0]), 1);
    chk("pre_reset busy0", int'(busy_o[0]), 1);
    #2 reset = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    reset = 1'b1;
    build(0, 2);
    run_vecs(4'hF, 0);
    @(negedge clk);
    start = 1'b1;
    mon_rst = 1'b0;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (!done_o[0] && c < 40) begin
      @(negedge clk);
      mon_en = 1'($urandom);
      mon_d = 1'($urandom);
      c++;
    end
    chk("no_mon_rst timeout", c, 40);
    chk("no_mon_rst busy", int'(busy_o), 15);
    chk("no_mon_rst done", int'(done_o), 0);
    reset = 1'b0;
    #1 chk_zero("final_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dff_resp_checker.md
Name: dff_resp_checker

Overview:
- Synthesizable response monitor for the enabled D flip-flop (ports clk/reset/enable/d/q/qb).
- Where a stimulus driver produces d/enable/reset, this block consumes them together with the flop's q/qb. It runs a cycle-exact reference model, compares every clock, and reports pass/fail, an error count and the first failing cycle.
- Placed alongside the flop in sequential exercises so that benches and on-board demos check themselves.

Parameters:
- NUM_CHECKS, 32: number of compared cycles per run; minimum 1.
- CNT_W, 8: width of the cycle counter and fail_cyc; must hold NUM_CHECKS.
- ERR_W, 8: width of the error counter; the counter saturates.
- STOP_ON_FAIL, 0: 1 ends the run on the first mismatch; 0 keeps checking to NUM_CHECKS.

Ports:
- clk, input, 1: single clock; all checker state updates on its rising edge.
- reset, input, 1: asynchronous, active-low checker reset (0 = reset).
- start, input, 1: pulse high for one cycle to arm a run; ignored while busy.
- mon_rst, input, 1: observed flop reset, active-high (the flop's own reset, not the checker's).
- mon_en, input, 1: observed flop enable.
- mon_d, input, 1: observed flop data input.
- mon_q, input, 1: observed flop q.
- mon_qb, input, 1: observed flop qb.
- busy, output, 1: a run is in progress (states WAIT_RST or CHECK).
- done, output, 1: run finished; sticky until the next start.
- pass, output, 1: valid only when done=1; 1 means zero errors.
- err_cnt, output, ERR_W: mismatching cycles, saturating at all-ones.
- fail_cyc, output, CNT_W: value of cyc_cnt at the first mismatch; 0 if none.
- fail_code, output, 2: first-failure cause. Bit0 = q differs from the model. Bit1 = qb is not the complement of q.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, exp_q=0, cyc_cnt=0.
  - busy=0, done=0, pass=0, err_cnt=0, fail_cyc=0, fail_code=0.
  - Reset applied mid-run aborts the run immediately; no partial result is retained.
- States:
  - IDLE: on start=1, go to WAIT_RST and clear done, pass, err_cnt, fail_cyc, fail_code and cyc_cnt.
  - WAIT_RST: no comparisons, because the flop value is unknown before its reset. On a sampled edge with mon_rst=1, set exp_q=0 and go to CHECK.
  - CHECK: compare every edge (rules below), then increment cyc_cnt.
    - When the incremented cyc_cnt equals NUM_CHECKS, go to DONE.
    - If STOP_ON_FAIL=1 and this edge mismatched, go to DONE.
  - DONE: done=1, pass=(err_cnt==0), busy=0. A start pulse returns to WAIT_RST with the same clears as from IDLE.
- Compare rules in CHECK, applied at each rising clk edge using pre-edge values:
  - Expected q: 0 if mon_rst=1, otherwise exp_q. The flop resets asynchronously, so q must already be 0 while mon_rst is high.
  - mis_q = (mon_q != expected q).
  - mis_qb = (mon_qb != ~mon_q).
  - mismatch = mis_q OR mis_qb.
  - On a mismatch, increment err_cnt (saturating). If this is the first mismatch of the run, capture fail_cyc = cyc_cnt (pre-increment) and fail_code = {mis_qb, mis_q}.
  - X/Z on mon_q or mon_qb counts as a mismatch; in simulation, compare with !==.
- Model update, after the compare on the same edge:
  - If mon_rst=1: exp_q=0.
  - Else if mon_en=1: exp_q=mon_d.
  - Else: exp_q holds.
  - The update happens in WAIT_RST and in CHECK.
- Latency:
  - A flop error caused by edge k is flagged at edge k+1.
  - err_cnt updates one cycle after the faulty q appears.
  - done rises on the edge following the last compared cycle.
- Boundaries:
  - start while busy: ignored.
  - start and reset=0 together: reset wins.
  - mon_rst never asserted: the checker stays in WAIT_RST and busy stays 1. This is intentional; the bench detects it with a timeout.
  - mon_rst toggling during CHECK: the model follows it and the comparison stays valid.
  - NUM_CHECKS=1: exactly one compare, then DONE.
  - err_cnt at all-ones stays there; pass remains 0.

Test Plan:
1. Good flop, 32 cycles:
   - Stimulus: start, mon_rst=1 for 2 cycles, then random d/en.
   - Required: done=1, pass=1, err_cnt=0, fail_cyc=0, fail_code=0.
2. Injected q stuck-at-1:
   - Stimulus: force mon_q=1 from check cycle 5 while the model expects 0.
   - Required: fail_cyc=5, fail_code=01, err_cnt>=1, pass=0.
3. qb error:
   - Stimulus: force mon_qb=mon_q at cycle 3.
   - Required: fail_code=10, fail_cyc=3, err_cnt=1.
4. Enable low hold:
   - Stimulus: en=0 with d toggling for 10 cycles after loading d=1.
   - Required: model holds 1, no errors; if the flop is forced to follow d, err_cnt=5 (d disagrees on 5 of the 10 cycles).
5. STOP_ON_FAIL=1 with a mismatch at cycle 2:
   - Required: done at cycle 3, err_cnt=1, busy=0.
6. Checker reset:
   - Stimulus: reset=0 at cycle 10 of a run.
   - Required: busy=0, done=0 and err_cnt=0 immediately without a clock edge. A new start plus mon_rst then gives a clean pass.
